// File: rtl/ltc2308_pkg.sv
// Shared types, sizes and helpers for the LTC2308 converter emulation.
// The channel decode and data formatting live here so the top and any future checkers agree.
package ltc2308_pkg;

    localparam int CFG_BITS  = 6;
    localparam int DATA_BITS = 12;
    localparam int CH_BITS   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2,
        SHIFT   = 2'd3
    } state_e;

    // Config word layout: {S/D, O/S, S1, S0, UNI, SLP}
    function automatic logic [CH_BITS-1:0] cfg_to_ch(input logic [CFG_BITS-1:0] cfg);
        return {cfg[3], cfg[2], cfg[4]};
    endfunction

    // Bipolar mode presents the raw offset-binary code as two's complement
    function automatic logic [DATA_BITS-1:0] format_data(input logic [DATA_BITS-1:0] smp,
                                                         input logic [CFG_BITS-1:0]  cfg);
        logic [DATA_BITS-1:0] word_v;
        if (cfg[1]) begin
            word_v = smp;
        end else begin
            word_v = smp ^ 12'h800;
        end
        return word_v;
    endfunction

endpackage

// File: rtl/ltc2308_responder_if.sv
// ADC pin bundle plus the user-side sample request/response port.
// master = FPGA initiator and sample source, slave = the emulated converter.
interface ltc2308_responder_if;
    import ltc2308_pkg::*;

    logic                 ADC_CONVST;
    logic                 ADC_SCK;
    logic                 ADC_SDI;
    logic                 ADC_SDO;
    logic                 sample_req;
    logic [CH_BITS-1:0]   ch_sel;
    logic [DATA_BITS-1:0] sample;

    modport master (
        output ADC_CONVST, ADC_SCK, ADC_SDI, sample,
        input  ADC_SDO, sample_req, ch_sel
    );

    modport slave (
        input  ADC_CONVST, ADC_SCK, ADC_SDI, sample,
        output ADC_SDO, sample_req, ch_sel
    );

endinterface

// File: rtl/ltc2308_responder_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall pulses
// taken against one extra history flop (pulses appear 2 clk after the pin moves).
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/ltc2308_responder.sv
// Converter-side emulation of the LTC2308 serial link: conversion on CONVST,
// 6-bit config in on SDI, 12-bit result out on SDO, samples fetched from the user port.
module ltc2308_responder
    import ltc2308_pkg::*;
#(
    parameter int                  CONV_CYCLES = 80,
    parameter logic [CFG_BITS-1:0] CFG_RESET   = 6'b100010
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ltc2308_responder_if.slave   adc,
    output logic                 busy,
    output logic [15:0]          conv_count
);

    localparam int                CNT_W    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    logic convst_level_s;
    logic convst_rise_s;
    logic convst_fall_s;
    logic sck_level_s;
    logic sck_rise_s;
    logic sck_fall_s;
    logic sdi_sync_s;
    logic sdi_rise_s;
    logic sdi_fall_s;
    logic unused_s;
    logic start_s;
    logic [DATA_BITS-1:0] data_next_s;

    state_e               state_r;
    logic                 sdo_r;
    logic                 sample_req_r;
    logic                 busy_r;
    logic [CH_BITS-1:0]   ch_sel_r;
    logic [15:0]          conv_count_r;
    logic [CFG_BITS-1:0]  cfg_active_r;
    logic [CFG_BITS-1:0]  cfg_pend_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           bit_idx_r;
    logic [3:0]           rise_cnt_r;
    logic [DATA_BITS-1:0] data_r;

    sync_edge u_sync_convst (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (adc.ADC_CONVST),
        .level (convst_level_s),
        .rise  (convst_rise_s),
        .fall  (convst_fall_s)
    );

    sync_edge u_sync_sck (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (adc.ADC_SCK),
        .level (sck_level_s),
        .rise  (sck_rise_s),
        .fall  (sck_fall_s)
    );

    sync_edge u_sync_sdi (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (adc.ADC_SDI),
        .level (sdi_sync_s),
        .rise  (sdi_rise_s),
        .fall  (sdi_fall_s)
    );

    assign unused_s    = &{1'b0, convst_level_s, convst_fall_s, sck_level_s, sdi_rise_s, sdi_fall_s};
    // A CONVST rise restarts from any state except an ongoing conversion
    assign start_s     = convst_rise_s && (state_r != CONVERT);
    assign data_next_s = format_data(adc.sample, cfg_active_r);

    // Conversion / readout state machine with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            sdo_r        <= 1'b0;
            sample_req_r <= 1'b0;
            busy_r       <= 1'b0;
            ch_sel_r     <= 3'd0;
            conv_count_r <= 16'd0;
            cfg_active_r <= CFG_RESET;
            cfg_pend_r   <= 6'd0;
            cnt_r        <= '0;
            bit_idx_r    <= 4'd0;
            rise_cnt_r   <= 4'd0;
            data_r       <= 12'd0;
        end else begin
            sample_req_r <= 1'b0;
            if (start_s) begin
                state_r      <= CONVERT;
                sample_req_r <= 1'b1;
                busy_r       <= 1'b1;
                ch_sel_r     <= cfg_to_ch(cfg_active_r);
                cnt_r        <= '0;
                cfg_pend_r   <= 6'd0;
                rise_cnt_r   <= 4'd0;
                sdo_r        <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        sdo_r <= 1'b0;
                    end
                    CONVERT: begin
                        if (cnt_r == CNT_LAST) begin
                            data_r       <= data_next_s;
                            sdo_r        <= data_next_s[DATA_BITS-1];
                            conv_count_r <= conv_count_r + 16'd1;
                            busy_r       <= 1'b0;
                            bit_idx_r    <= 4'(DATA_BITS - 1);
                            rise_cnt_r   <= 4'd0;
                            state_r      <= READY;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                            sdo_r <= 1'b0;
                        end
                    end
                    READY, SHIFT: begin
                        if (sck_rise_s) begin
                            state_r    <= SHIFT;
                            rise_cnt_r <= rise_cnt_r + 4'd1;
                            if (rise_cnt_r < 4'(CFG_BITS)) begin
                                cfg_pend_r <= {cfg_pend_r[CFG_BITS-2:0], sdi_sync_s};
                            end
                            // Twelfth rise ends the frame; a complete config takes effect next time
                            if (rise_cnt_r == 4'(DATA_BITS - 1)) begin
                                state_r <= IDLE;
                                sdo_r   <= 1'b0;
                                if (rise_cnt_r >= 4'(CFG_BITS)) begin
                                    cfg_active_r <= cfg_pend_r;
                                end
                            end
                        end else if (sck_fall_s) begin
                            state_r <= SHIFT;
                            if (bit_idx_r != 4'd0) begin
                                bit_idx_r <= bit_idx_r - 4'd1;
                                sdo_r     <= data_r[bit_idx_r - 4'd1];
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        sdo_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adc.ADC_SDO    = sdo_r;
    assign adc.sample_req = sample_req_r;
    assign adc.ch_sel     = ch_sel_r;
    assign busy           = busy_r;
    assign conv_count     = conv_count_r;

endmodule

// File: tb/tb_ltc2308_responder.sv
// Randomized bench for ltc2308_responder: an initiator drives the pins, and a
// transaction-level model predicts channel, readback word, config and count.
module tb_ltc2308_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        busy;
    logic [15:0] conv_count;

    always #10 clk = ~clk;

    ltc2308_responder_if bus();

    ltc2308_responder #(
        .CONV_CYCLES (80),
        .CFG_RESET   (6'b100010)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc        (bus),
        .busy       (busy),
        .conv_count (conv_count)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [5:0]  cfg_m;
    logic [15:0] conv_m;
    logic [11:0] exp_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Channel number = 4*S1 + 2*S0 + O/S
    function automatic int model_channel(input logic [5:0] c);
        return 4 * int'(c[3]) + 2 * int'(c[2]) + int'(c[4]);
    endfunction

    // Unipolar: raw code. Bipolar: code minus mid-scale, modulo 4096.
    function automatic logic [11:0] model_word(input logic [11:0] s, input logic [5:0] c);
        if (c[1]) return s;
        return s + 12'd2048;
    endfunction

    task automatic start_conv(input logic [11:0] smp, input bit glitch);
        int lat;
        int width;
        int reqs;
        bus.sample = smp;
        exp_m      = model_word(smp, cfg_m);
        @(negedge clk);
        bus.ADC_CONVST = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.sample_req) begin
                lat = i;
                break;
            end
        end
        check_eq("req_latency", lat, 3);
        check_eq("busy_with_req", busy, 1'b1);
        check_eq("ch_sel", bus.ch_sel, model_channel(cfg_m));
        width = 0;
        reqs  = 0;
        while (busy && width < 200) begin
            width++;
            @(negedge clk);
            if (width == 3)            bus.ADC_CONVST = 1'b0;
            if (glitch && width == 20) bus.ADC_CONVST = 1'b1;
            if (glitch && width == 30) bus.ADC_CONVST = 1'b0;
            if (bus.sample_req) reqs++;
        end
        bus.ADC_CONVST = 1'b0;
        check_eq("busy_width", width, 80);
        check_eq("extra_req", reqs, 0);
        conv_m = conv_m + 16'd1;
        check_eq("conv_count", conv_count, conv_m);
        check_eq("sdo_first", bus.ADC_SDO, exp_m[11]);
    endtask

    task automatic transfer(input int n, input logic [5:0] cfg_bits, output logic [11:0] got);
        got = 12'd0;
        for (int k = 0; k < n; k++) begin
            bus.ADC_SDI = (k < 6) ? cfg_bits[5 - k] : 1'($urandom);
            repeat (5) @(negedge clk);
            got[11 - k] = bus.ADC_SDO;
            bus.ADC_SCK = 1'b1;
            repeat (5) @(negedge clk);
            bus.ADC_SCK = 1'b0;
        end
        if (n == 12) cfg_m = cfg_bits;
    endtask

    task automatic run_txn(input logic [11:0] smp, input logic [5:0] cfg_bits,
                           input int n, input bit glitch);
        logic [11:0] got;
        logic [11:0] mask;
        start_conv(smp, glitch);
        transfer(n, cfg_bits, got);
        mask = 12'hFFF << (12 - n);
        check_eq("readback", got & mask, exp_m & mask);
        if (n == 12) begin
            repeat (5) @(negedge clk);
            check_eq("sdo_idle", bus.ADC_SDO, 1'b0);
        end
    endtask

    initial begin
        logic [11:0] got;
        reset_n        = 1'b1;
        bus.ADC_CONVST = 1'b0;
        bus.ADC_SCK    = 1'b0;
        bus.ADC_SDI    = 1'b0;
        bus.sample     = 12'd0;
        cfg_m          = 6'b100010;
        conv_m         = 16'd0;
        #5 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sdo", bus.ADC_SDO, 1'b0);
        check_eq("rst_req", bus.sample_req, 1'b0);
        check_eq("rst_ch", bus.ch_sel, 3'd0);
        check_eq("rst_count", conv_count, 16'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        run_txn(12'hABC, 6'b110010, 12, 1'b0);
        run_txn(12'h123, 6'b100000, 12, 1'b0);
        run_txn(12'h000, 6'b101110, 5, 1'b0);
        run_txn(12'h5A5, 6'b110110, 12, 1'b1);

        for (int t = 0; t < 10; t++) begin
            logic [11:0] s;
            logic [5:0]  c;
            int          n;
            s = 12'($urandom);
            c = 6'($urandom);
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 11)) : 12;
            run_txn(s, c, n, 1'($urandom));
        end

        start_conv(12'($urandom), 1'b0);
        transfer(7, 6'b011101, got);
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_eq("midrst_sdo", bus.ADC_SDO, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_count", conv_count, 16'd0);
        check_eq("midrst_ch", bus.ch_sel, 3'd0);
        cfg_m  = 6'b100010;
        conv_m = 16'd0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(12'hFED, 6'b000000, 12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
